// File: rtl/life_if.sv
// life_if: control, seed, step and read-port signals of life_core.
// master drives requests and reads; slave is the engine.
interface life_if #(
    parameter int COLS = 16,
    parameter int ROWS = 16
);
    localparam int XW = $clog2(COLS);
    localparam int YW = $clog2(ROWS);
    localparam int PW = $clog2(COLS * ROWS + 1);

    logic                   seed_load;
    logic [COLS*ROWS-1:0]   seed_in;
    logic                   step_req;
    logic                   wrap_en;
    logic [XW-1:0]          rd_x;
    logic [YW-1:0]          rd_y;
    logic                   rd_cell;
    logic                   busy;
    logic                   step_done;
    logic [15:0]            gen_count;
    logic [PW-1:0]          pop_count;

    modport master (
        output seed_load, seed_in, step_req, wrap_en, rd_x, rd_y,
        input  rd_cell, busy, step_done, gen_count, pop_count
    );

    modport slave (
        input  seed_load, seed_in, step_req, wrap_en, rd_x, rd_y,
        output rd_cell, busy, step_done, gen_count, pop_count
    );
endinterface

// File: rtl/life_core.sv
// life_core: Game-of-Life engine, one grid row per cycle.
// Optional LIFE_POPCOUNT_EN builds the live-cell counter.
module life_core #(
    parameter int         COLS         = 16,
    parameter int         ROWS         = 16,
    parameter logic [8:0] BIRTH_MASK   = 9'b000001000,
    parameter logic [8:0] SURVIVE_MASK = 9'b000001100,
    parameter int         XW           = $clog2(COLS),
    parameter int         YW           = $clog2(ROWS)
) (
    input  logic  clk,
    input  logic  rst,
    life_if.slave bus
);
    localparam int N  = COLS * ROWS;
    localparam int IW = $clog2(N);
    localparam int PW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, COMPUTE, COMMIT} state_t;

    state_t          state, state_nx;
    logic [N-1:0]    cur, nxt;
    logic [YW-1:0]   r;
    logic            wrap;
    logic [15:0]     gen;
    logic [COLS-1:0] row_nxt;
    logic            rd_hit, rd_q;
    logic [XW-1:0]   rx;
    logic [YW-1:0]   ry;

    assign rx = bus.rd_x;
    assign ry = bus.rd_y;

    // next-state decode; a seed load always returns to IDLE
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.step_req) state_nx = COMPUTE;
            COMPUTE: if (r == YW'(ROWS - 1)) state_nx = COMMIT;
            COMMIT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (bus.seed_load) state_nx = IDLE;
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next generation of row r from rows r-1..r+1 of cur
    always_comb begin
        logic [3:0] cnt;
        logic       alive;
        int         xx, yy;
        row_nxt = '0;
        cnt     = '0;
        alive   = 1'b0;
        xx      = 0;
        yy      = 0;
        for (int x = 0; x < COLS; x++) begin
            cnt = '0;
            for (int dy = -1; dy <= 1; dy++) begin
                for (int dx = -1; dx <= 1; dx++) begin
                    if (dy != 0 || dx != 0) begin
                        yy = int'(r) + dy;
                        xx = x + dx;
                        if (wrap) begin
                            yy = (yy + ROWS) % ROWS;
                            xx = (xx + COLS) % COLS;
                        end
                        if (xx >= 0 && xx < COLS && yy >= 0 && yy < ROWS)
                            cnt = cnt + 4'(cur[IW'(yy * COLS + xx)]);
                    end
                end
            end
            alive      = cur[IW'(int'(r) * COLS + x)];
            row_nxt[x] = alive ? SURVIVE_MASK[cnt] : BIRTH_MASK[cnt];
        end
    end

    // grid, row counter, wrap latch and generation counter
    always_ff @(posedge clk) begin
        if (rst) begin
            cur  <= '0;
            nxt  <= '0;
            r    <= '0;
            wrap <= 1'b0;
            gen  <= '0;
        end else if (bus.seed_load) begin
            cur <= bus.seed_in;
            gen <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.step_req) begin
                        r    <= '0;
                        wrap <= bus.wrap_en;
                    end
                end
                COMPUTE: begin
                    nxt[IW'(int'(r) * COLS) +: COLS] <= row_nxt;
                    r <= r + 1'b1;
                end
                COMMIT: begin
                    cur <= nxt;
                    gen <= gen + 16'd1;
                end
                default: ;
            endcase
        end
    end

    // registered read of the current generation
    always_comb begin
        rd_hit = 1'b0;
        if (int'(rx) < COLS && int'(ry) < ROWS)
            rd_hit = cur[IW'(int'(ry) * COLS + int'(rx))];
    end

    // read-port output register
    always_ff @(posedge clk) begin
        if (rst) rd_q <= 1'b0;
        else     rd_q <= rd_hit;
    end

    assign bus.rd_cell   = rd_q;
    assign bus.busy      = (state != IDLE);
    assign bus.step_done = (state == COMMIT);
    assign bus.gen_count = gen;

`ifdef LIFE_POPCOUNT_EN
    logic [PW-1:0] acc, pop;

    function automatic logic [PW-1:0] popc(input logic [N-1:0] v);
        logic [PW-1:0] c;
        c = '0;
        for (int i = 0; i < N; i++) c = c + PW'(v[i]);
        return c;
    endfunction

    // accumulate row popcounts; publish at commit or seed
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            pop <= '0;
        end else if (bus.seed_load) begin
            acc <= '0;
            pop <= popc(bus.seed_in);
        end else begin
            unique case (state)
                IDLE:    if (bus.step_req) acc <= '0;
                COMPUTE: acc <= acc + popc({{(N-COLS){1'b0}}, row_nxt});
                COMMIT:  pop <= acc;
                default: ;
            endcase
        end
    end

    assign bus.pop_count = pop;
`else
    assign bus.pop_count = '0;
`endif
endmodule
